// File: rtl/fadd_pkg.sv
// Shared types, constants and operand unpack helpers for the binary32 pipelined adder.
package fadd_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned GRS_W    = 3;
  localparam int unsigned EXT_W    = MANT_W + GRS_W;
  localparam int unsigned SUM_W    = EXT_W + 1;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} op_class_e;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
    op_class_e         cls;
  } operand_t;

  // Denormals collapse to signed zero with exponent and mantissa cleared
  function automatic operand_t unpack(float32_t f);
    operand_t o;
    o.sign = f.sign;
    if (f.exp == 8'h00)      o.cls = ZERO;
    else if (f.exp == 8'hFF) o.cls = (f.frac == 23'd0) ? INF : NAN;
    else                     o.cls = NORMAL;
    o.exp  = (o.cls == ZERO) ? 8'h00 : f.exp;
    o.mant = (o.cls == NORMAL) ? {1'b1, f.frac} : '0;
    return o;
  endfunction

  function automatic logic [31:0] inf_of(logic sign);
    return sign ? NEG_INF : POS_INF;
  endfunction

endpackage

// File: rtl/fadd_if.sv
// Operand/result bundle between the FPU issue logic and the adder pipeline.
interface fadd_if;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [31:0] y;

  modport master (output x1, output x2, input y);
  modport slave  (input x1, input x2, output y);
endinterface

// File: rtl/fadd_lzc.sv
// Combinational leading-zero counter over the 28-bit raw sum; all-zero input returns 28.
module fadd_lzc
  import fadd_pkg::*;
(
  input  logic [SUM_W-1:0] a,
  output logic [4:0]       lz_c
);

  always_comb begin
    logic found;
    lz_c  = 5'd28;
    found = 1'b0;
    for (int i = SUM_W - 1; i >= 0; i--) begin
      if (!found && a[i]) begin
        lz_c  = 5'(SUM_W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// Seven-stage binary32 adder: unpack, swap, align, add, lzc, normalise, round/pack.
module fadd_pipe
  import fadd_pkg::*;
#(
  parameter int unsigned NSTAGE = 7
) (
  input  logic   clk,
  input  logic   rstn,
  fadd_if.slave  bus
);

  localparam int unsigned ALIGN_MAX = EXT_W - 1;
  localparam int unsigned WIDE_W    = EXT_W + ALIGN_MAX;

  if (NSTAGE != 7) begin : g_nstage_chk
    $error("fadd_pipe supports NSTAGE=7 only");
  end

  // Stage 1: unpack and classify
  operand_t s1_a, s1_b;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_a <= '0;
      s1_b <= '0;
    end else begin
      s1_a <= unpack(float32_t'(bus.x1));
      s1_b <= unpack(float32_t'(bus.x2));
    end
  end

  // Stage 2: magnitude swap and special-case resolution
  logic              swap_c, spec_c;
  logic [31:0]       spec_val_c;
  logic [7:0]        big_exp_c, small_exp_c;
  logic [MANT_W-1:0] big_mant_c, small_mant_c;

  always_comb begin
    swap_c       = {s1_b.exp, s1_b.mant} > {s1_a.exp, s1_a.mant};
    big_exp_c    = swap_c ? s1_b.exp  : s1_a.exp;
    small_exp_c  = swap_c ? s1_a.exp  : s1_b.exp;
    big_mant_c   = swap_c ? s1_b.mant : s1_a.mant;
    small_mant_c = swap_c ? s1_a.mant : s1_b.mant;
    spec_c       = 1'b1;
    spec_val_c   = QNAN;
    if (s1_a.cls == NAN || s1_b.cls == NAN) spec_val_c = QNAN;
    else if (s1_a.cls == INF && s1_b.cls == INF)
      spec_val_c = (s1_a.sign != s1_b.sign) ? QNAN : inf_of(s1_a.sign);
    else if (s1_a.cls == INF) spec_val_c = inf_of(s1_a.sign);
    else if (s1_b.cls == INF) spec_val_c = inf_of(s1_b.sign);
    else if (s1_a.cls == ZERO && s1_b.cls == ZERO)
      spec_val_c = {s1_a.sign & s1_b.sign, 31'd0};
    else spec_c = 1'b0;
  end

  logic              s2_sign, s2_sub, s2_spec;
  logic [7:0]        s2_exp, s2_shift;
  logic [MANT_W-1:0] s2_big, s2_small;
  logic [31:0]       s2_spec_val;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_sign <= 1'b0; s2_sub <= 1'b0; s2_spec <= 1'b0;
      s2_exp <= '0; s2_shift <= '0; s2_big <= '0; s2_small <= '0; s2_spec_val <= '0;
    end else begin
      s2_sign     <= swap_c ? s1_b.sign : s1_a.sign;
      s2_sub      <= s1_a.sign ^ s1_b.sign;
      s2_spec     <= spec_c;
      s2_exp      <= big_exp_c;
      s2_shift    <= big_exp_c - small_exp_c;
      s2_big      <= big_mant_c;
      s2_small    <= small_mant_c;
      s2_spec_val <= spec_val_c;
    end
  end

  // Stage 3: align smaller operand, folding shifted-out bits into sticky
  logic [WIDE_W-1:0] wide_c;
  logic [EXT_W-1:0]  small_ext_c;
  always_comb begin
    wide_c = {s2_small, {(WIDE_W-MANT_W){1'b0}}} >> s2_shift;
    if (s2_shift >= 8'(ALIGN_MAX))
      small_ext_c = {{(EXT_W-1){1'b0}}, |s2_small};
    else
      small_ext_c = {wide_c[WIDE_W-1 -: EXT_W-1], |wide_c[ALIGN_MAX:0]};
  end

  logic             s3_sign, s3_sub, s3_spec;
  logic [7:0]       s3_exp;
  logic [EXT_W-1:0] s3_big, s3_small;
  logic [31:0]      s3_spec_val;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_sign <= 1'b0; s3_sub <= 1'b0; s3_spec <= 1'b0;
      s3_exp <= '0; s3_big <= '0; s3_small <= '0; s3_spec_val <= '0;
    end else begin
      s3_sign     <= s2_sign;
      s3_sub      <= s2_sub;
      s3_spec     <= s2_spec;
      s3_exp      <= s2_exp;
      s3_big      <= {s2_big, {GRS_W{1'b0}}};
      s3_small    <= small_ext_c;
      s3_spec_val <= s2_spec_val;
    end
  end

  // Stage 4: magnitude add/subtract; big >= small so the difference never goes negative
  logic             s4_sign, s4_spec;
  logic [7:0]       s4_exp;
  logic [SUM_W-1:0] s4_sum;
  logic [31:0]      s4_spec_val;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s4_sign <= 1'b0; s4_spec <= 1'b0; s4_exp <= '0; s4_sum <= '0; s4_spec_val <= '0;
    end else begin
      s4_sign     <= s3_sign;
      s4_spec     <= s3_spec;
      s4_exp      <= s3_exp;
      s4_sum      <= s3_sub ? ({1'b0, s3_big} - {1'b0, s3_small})
                            : ({1'b0, s3_big} + {1'b0, s3_small});
      s4_spec_val <= s3_spec_val;
    end
  end

  // Stage 5: leading-zero count
  logic [4:0] lz_c;
  fadd_lzc u_lzc (.a(s4_sum), .lz_c(lz_c));

  logic             s5_sign, s5_spec;
  logic [7:0]       s5_exp;
  logic [4:0]       s5_lz;
  logic [SUM_W-1:0] s5_sum;
  logic [31:0]      s5_spec_val;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s5_sign <= 1'b0; s5_spec <= 1'b0; s5_exp <= '0; s5_lz <= '0; s5_sum <= '0;
      s5_spec_val <= '0;
    end else begin
      s5_sign     <= s4_sign;
      s5_spec     <= s4_spec;
      s5_exp      <= s4_exp;
      s5_lz       <= lz_c;
      s5_sum      <= s4_sum;
      s5_spec_val <= s4_spec_val;
    end
  end

  // Stage 6: normalise; a negative or zero biased exponent flushes to signed zero
  logic [EXT_W-1:0] norm_c;
  logic [9:0]       ex_c;
  logic             zero_sum_c, uflow_c;
  always_comb begin
    zero_sum_c = (s5_sum == '0);
    if (s5_sum[SUM_W-1]) begin
      norm_c = {s5_sum[SUM_W-1:2], |s5_sum[1:0]};
      ex_c   = {2'b00, s5_exp} + 10'd1;
    end else begin
      norm_c = EXT_W'(s5_sum << (s5_lz - 5'd1));
      ex_c   = {2'b00, s5_exp} + 10'd1 - {5'd0, s5_lz};
    end
    uflow_c = ex_c[9] || (ex_c == 10'd0);
  end

  logic             s6_sign, s6_zero, s6_spec;
  logic [7:0]       s6_exp;
  logic [EXT_W-1:0] s6_norm;
  logic [31:0]      s6_spec_val;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s6_sign <= 1'b0; s6_zero <= 1'b0; s6_spec <= 1'b0; s6_exp <= '0; s6_norm <= '0;
      s6_spec_val <= '0;
    end else begin
      s6_sign     <= zero_sum_c ? 1'b0 : s5_sign;
      s6_zero     <= zero_sum_c | uflow_c;
      s6_spec     <= s5_spec;
      s6_exp      <= ex_c[7:0];
      s6_norm     <= norm_c;
      s6_spec_val <= s5_spec_val;
    end
  end

  // Stage 7: round to nearest even, pack, special-case select
  logic [MANT_W:0] mant_r_c;
  logic [8:0]      exp_r_c;
  logic            up_c;
  logic [31:0]     res_c;
  always_comb begin
    up_c     = s6_norm[2] & (s6_norm[1] | s6_norm[0] | s6_norm[GRS_W]);
    mant_r_c = {1'b0, s6_norm[EXT_W-1:GRS_W]} + (MANT_W+1)'(up_c);
    exp_r_c  = {1'b0, s6_exp} + 9'(mant_r_c[MANT_W]);
    if (s6_spec)                      res_c = s6_spec_val;
    else if (s6_zero)                 res_c = {s6_sign, 31'd0};
    else if (exp_r_c >= 9'(EXP_MAX))  res_c = inf_of(s6_sign);
    else if (mant_r_c[MANT_W])        res_c = {s6_sign, exp_r_c[7:0], mant_r_c[MANT_W-1:1]};
    else                              res_c = {s6_sign, exp_r_c[7:0], mant_r_c[MANT_W-2:0]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bus.y <= '0;
    else       bus.y <= res_c;
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Self-checking bench for fadd_pipe: directed corner cases plus random pairs against a double-precision reference.
module tb_fadd_pipe;

  localparam int unsigned NSTAGE = 7;
  localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rstn;
  fadd_if bus ();

  fadd_pipe #(.NSTAGE(NSTAGE)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    string       tag;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] da [14] = '{32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800001,
                           32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001,
                           32'hFF800000, 32'h00000001, 32'h00800000, 32'h00000000,
                           32'h7F800000, 32'h3F800000};
  logic [31:0] db [14] = '{32'hBF800000, 32'h80000000, 32'h33800000, 32'h33800000,
                           32'h33C00000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000,
                           32'h3F800000, 32'h00000000, 32'h80800001, 32'h80000000,
                           32'h7F800000, 32'hB3800000};
  logic [31:0] de [14] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800002,
                           32'h3F800001, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                           32'hFF800000, 32'h00000000, 32'h80000000, 32'h00000000,
                           32'h7F800000, 32'h3F7FFFFF};

  // Exact widening of a normal binary32 into a double
  function automatic real to_real(logic [31:0] f);
    logic [10:0] e11;
    e11 = 11'(int'(f[30:23]) + 896);
    return $bitstoreal({f[31], e11, f[22:0], 29'd0});
  endfunction

  // Reference: exact-enough double sum, then RNE to binary32 with flush-to-zero
  function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b);
    logic        na, nb, ia, ib, za, zb, s;
    real         rs;
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] keep;
    logic [28:0] rem;
    int          e;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    if (na || nb) return QNAN_C;
    if (ia && ib) return (a[31] != b[31]) ? QNAN_C : a;
    if (ia) return a;
    if (ib) return b;
    if (za && zb) return {a[31] & b[31], 31'd0};
    rs = (za ? 0.0 : to_real(a)) + (zb ? 0.0 : to_real(b));
    if (rs == 0.0) return 32'h0;
    d = $realtobits(rs);
    s = d[63];
    e = int'(d[62:52]) - 1023;
    if (e < -126) return {s, 31'd0};
    m    = {1'b1, d[51:0]};
    keep = {1'b0, m[52:29]};
    rem  = m[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      e    = e + 1;
      keep = 25'h080_0000;
    end
    if (e > 127) return {s, 8'hFF, 23'd0};
    return {s, 8'(e + 127), keep[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] e);
    checks++;
    assert (bus.y === e) else begin
      errors++;
      $error("FAIL %s: y=%h expected %h", tag, bus.y, e);
    end
  endtask

  task automatic refill();
    expq.delete();
    repeat (NSTAGE - 1) expq.push_back('{32'h0, "pre_result"});
  endtask

  // Drive one pair ahead of the next edge, then check the output emerging at that edge
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                      input string tag);
    exp_t x;
    @(negedge clk);
    bus.x1 = a;
    bus.x2 = b;
    expq.push_back('{e, tag});
    @(posedge clk);
    #1;
    x = expq.pop_front();
    check(x.tag, x.v);
  endtask

  function automatic logic [31:0] rand_b(logic [31:0] a);
    logic [31:0] b;
    logic [7:0]  eb;
    case ($urandom_range(0, 3))
      0: b = $urandom;
      1: begin
        eb = a[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
        b  = {1'($urandom), eb, 23'($urandom)};
      end
      2: b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 255))};
      default: b = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
    endcase
    return b;
  endfunction

  task automatic rand_steps(input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], 8'($urandom_range(1, 4)), a[22:0]};
      b = rand_b(a);
      step(a, b, ref_add(a, b), "rand");
    end
  endtask

  initial begin
    bus.x1 = 32'h0;
    bus.x2 = 32'h0;
    rstn   = 1'b1;
    #1 rstn = 1'b0;

    // Held reset: output stays zero whatever the inputs do
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.x1 = $urandom;
      bus.x2 = $urandom;
      @(posedge clk);
      #1;
      check("reset_hold", 32'h0);
    end
    bus.x1 = 32'h0;
    bus.x2 = 32'h0;
    @(posedge clk);
    #1 rstn = 1'b1;
    refill();

    // Latency: one result after NSTAGE edges, zero before
    step(32'h3F800000, 32'h3F800000, 32'h40000000, "latency");
    for (int i = 0; i < NSTAGE - 1; i++) step(32'h0, 32'h0, 32'h0, "latency_gap");

    // Directed corner cases back to back
    for (int i = 0; i < 14; i++) step(da[i], db[i], de[i], $sformatf("directed%0d", i));

    rand_steps(1500);

    // Mid-stream reset clears the pipe and output at once
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("reset_async", 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("reset_mid", 32'h0);
    end
    rstn = 1'b1;
    refill();

    rand_steps(1500);
    for (int i = 0; i < NSTAGE; i++) step(32'h0, 32'h0, 32'h0, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
